// File: rtl/bit_slicer_deser.sv
// Mid-bit slicer: samples the raw serial input using the measured bit period, hunts for a
// sync word, then deserialises bytes. `SYNC_INVERT_EN also accepts an inverted sync word.
module bit_slicer_deser #(
  parameter int unsigned           SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 16'hA5C3,
  parameter int unsigned           MIN_PERIOD = 4,
  parameter int unsigned           MAX_RUN    = 32,
  parameter bit                    MSB_FIRST  = 1'b1
) (
  input  logic        clk_200M,
  input  logic        rst_n,
  input  logic        signal,
  input  logic [15:0] bit_period,
  output logic        bit_val,
  output logic        bit_strobe,
  output logic        locked,
  output logic        sync_found,
  output logic        lock_lost,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        inverted,
  // Debug view of the FSM: 0 = IDLE, 1 = HUNT, 2 = LOCKED
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HUNT = 2'd1, ST_LOCKED = 2'd2} state_t;

  localparam int unsigned RUN_W = $clog2(MAX_RUN + 2);

  state_t                state_q, state_d;
  logic                  meta_q, meta_d, sig_s_q, sig_s_d, sig_dly_q, sig_dly_d;
  logic [15:0]           cnt_q, cnt_d, tgt_q, tgt_d;
  logic [SYNC_WIDTH-1:0] sreg_q, sreg_d;
  logic [7:0]            byte_q, byte_d, data_out_q, data_out_d;
  logic [2:0]            idx_q, idx_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  bit_val_q, bit_val_d, bit_strobe_q, bit_strobe_d;
  logic                  sync_found_q, sync_found_d, lock_lost_q, lock_lost_d;
  logic                  data_valid_q, data_valid_d;
  logic                  inv_q;

  logic                  edge_det, period_ok, take, data_bit;
  logic [SYNC_WIDTH-1:0] sreg_shift;
  logic [7:0]            byte_shift;
  logic [RUN_W-1:0]      run_inc;

`ifdef SYNC_INVERT_EN
  logic inv_d;
  assign data_bit = sig_s_q ^ inv_q;
`else
  assign inv_q    = 1'b0;
  assign data_bit = sig_s_q;
`endif

  assign edge_det   = sig_s_q ^ sig_dly_q;
  assign period_ok  = bit_period >= 16'(MIN_PERIOD);
  // A sample needs a counter hit without a competing edge and a valid period outside IDLE
  assign take       = !edge_det && (cnt_q == tgt_q) && period_ok && (state_q != ST_IDLE);
  assign sreg_shift = {sreg_q[SYNC_WIDTH-2:0], sig_s_q};
  assign byte_shift = MSB_FIRST ? {byte_q[6:0], data_bit} : {data_bit, byte_q[7:1]};
  assign run_inc    = (run_q == '1) ? run_q : run_q + 1'b1;

  always_comb begin
    meta_d       = signal;
    sig_s_d      = meta_q;
    sig_dly_d    = sig_s_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    state_d      = state_q;
    sreg_d       = sreg_q;
    byte_d       = byte_q;
    idx_d        = idx_q;
    run_d        = run_q;
    bit_val_d    = bit_val_q;
    bit_strobe_d = 1'b0;
    sync_found_d = 1'b0;
    lock_lost_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
`ifdef SYNC_INVERT_EN
    inv_d        = inv_q;
`endif

    if (edge_det) begin
      cnt_d = 16'd1;
      tgt_d = bit_period >> 1;
    end else if (cnt_q == tgt_q) begin
      cnt_d = 16'd1;
      tgt_d = bit_period;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (edge_det) begin
      run_d = '0;
    end else if (take) begin
      run_d = run_inc;
    end

    if (take) begin
      bit_val_d    = sig_s_q;
      bit_strobe_d = 1'b1;
    end

    // An invalid period overrides everything else that could happen this cycle
    if (!period_ok) begin
      state_d = ST_IDLE;
      sreg_d  = '0;
      run_d   = '0;
      idx_d   = 3'd0;
      byte_d  = 8'd0;
`ifdef SYNC_INVERT_EN
      inv_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_det) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (take) begin
            sreg_d = sreg_shift;
            if (sreg_shift == SYNC_WORD) begin
              sync_found_d = 1'b1;
              state_d      = ST_LOCKED;
              idx_d        = 3'd0;
`ifdef SYNC_INVERT_EN
              inv_d        = 1'b0;
            end else if (sreg_shift == ~SYNC_WORD) begin
              sync_found_d = 1'b1;
              state_d      = ST_LOCKED;
              idx_d        = 3'd0;
              inv_d        = 1'b1;
`endif
            end
          end
        end
        ST_LOCKED: begin
          if (take) begin
            if (run_inc > RUN_W'(MAX_RUN)) begin
              lock_lost_d = 1'b1;
              state_d     = ST_HUNT;
              sreg_d      = '0;
              idx_d       = 3'd0;
`ifdef SYNC_INVERT_EN
              inv_d       = 1'b0;
`endif
            end else begin
              byte_d = byte_shift;
              idx_d  = idx_q + 3'd1;
              if (idx_q == 3'd7) begin
                data_out_d   = byte_shift;
                data_valid_d = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      meta_q       <= 1'b0;
      sig_s_q      <= 1'b0;
      sig_dly_q    <= 1'b0;
      cnt_q        <= 16'd0;
      tgt_q        <= 16'd0;
      sreg_q       <= '0;
      byte_q       <= 8'd0;
      idx_q        <= 3'd0;
      run_q        <= '0;
      bit_val_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      sync_found_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      meta_q       <= meta_d;
      sig_s_q      <= sig_s_d;
      sig_dly_q    <= sig_dly_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      sreg_q       <= sreg_d;
      byte_q       <= byte_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      bit_val_q    <= bit_val_d;
      bit_strobe_q <= bit_strobe_d;
      sync_found_q <= sync_found_d;
      lock_lost_q  <= lock_lost_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef SYNC_INVERT_EN
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`endif

  assign bit_val    = bit_val_q;
  assign bit_strobe = bit_strobe_q;
  assign locked     = (state_q == ST_LOCKED);
  assign sync_found = sync_found_q;
  assign lock_lost  = lock_lost_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign inverted   = inv_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bit_slicer_deser.sv
// Bench for bit_slicer_deser: NRZ driver, negedge monitor with an expected-byte queue,
// one task per scenario.
`timescale 1ns/1ps
module tb_bit_slicer_deser;
  localparam int BIT = 100;

  logic        clk_200M = 1'b0;
  logic        rst_n = 1'b0;
  logic        signal = 1'b0;
  logic [15:0] bit_period = 16'd100;
  logic        bit_val, bit_strobe, locked, sync_found, lock_lost, data_valid, inverted;
  logic [7:0]  data_out;
  logic [1:0]  dbg_state;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int sync_cnt = 0, lost_cnt = 0, valid_cnt = 0, strobe_cnt = 0;
  int first_strobe_cyc = -1, last_strobe_cyc = -1, strobe_at_lost = -1;
  bit check_spacing = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  bit_slicer_deser dut (
    .clk_200M(clk_200M), .rst_n(rst_n), .signal(signal), .bit_period(bit_period),
    .bit_val(bit_val), .bit_strobe(bit_strobe), .locked(locked), .sync_found(sync_found),
    .lock_lost(lock_lost), .data_out(data_out), .data_valid(data_valid),
    .inverted(inverted), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #2.5 clk_200M = ~clk_200M;
  always @(posedge clk_200M) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Monitor / scoreboard
  always @(negedge clk_200M) begin
    if (bit_strobe) begin
      strobe_cnt++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      if (check_spacing && last_strobe_cyc >= 0) begin
        n_vec++;
        if ((cyc - last_strobe_cyc) !== BIT) begin
          n_err++;
          $display("FAIL strobe_spacing: got %0d cycles, expected %0d", cyc - last_strobe_cyc, BIT);
        end
      end
      last_strobe_cyc = cyc;
    end
    if (sync_found) sync_cnt++;
    if (lock_lost) begin
      lost_cnt++;
      strobe_at_lost = strobe_cnt;
    end
    if (data_valid) begin
      valid_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL data_valid_unexpected: data_out=%02h, expected no strobe", data_out);
      end else begin
        exp_byte = exp_q.pop_front();
        if (data_out !== exp_byte) begin
          n_err++;
          $display("FAIL data_out: got %02h, expected %02h", data_out, exp_byte);
        end
      end
    end
  end

  // Driver tasks: begin and end 1 time unit after a rising edge
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      signal = v[i];
      repeat (BIT) @(posedge clk_200M);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_200M);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; signal = 1'b0; bit_period = 16'd100;
    idle_cycles(4);
    n_vec++;
    if ({bit_val, bit_strobe, locked, sync_found, lock_lost, data_valid, inverted} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %07b, expected 0000000",
               {bit_val, bit_strobe, locked, sync_found, lock_lost, data_valid, inverted});
    end
    n_vec++;
    if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %02h, expected 00", data_out); end
    n_vec++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", dbg_state); end
    rst_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_lock_first_byte;
    int s0, v0, t0;
    s0 = sync_cnt; v0 = valid_cnt;
    first_strobe_cyc = -1;
    send_bits(32'h0, 1);
    t0 = cyc;
    send_bits(32'h55, 7);
    send_bits(32'hA5C3, 16);
    exp_q.push_back(8'h3C);
    send_bits(32'h3C, 8);
    n_vec++;
    if ((first_strobe_cyc - t0) !== 53) begin
      n_err++; $display("FAIL first_sample_delay: got %0d cycles, expected 53", first_strobe_cyc - t0);
    end
    n_vec++;
    if ((sync_cnt - s0) !== 1) begin n_err++; $display("FAIL lock_sync_count: got %0d, expected 1", sync_cnt - s0); end
    n_vec++;
    if (locked !== 1'b1) begin n_err++; $display("FAIL lock_locked: got %b, expected 1", locked); end
    n_vec++;
    if ((valid_cnt - v0) !== 1) begin n_err++; $display("FAIL lock_valid_count: got %0d, expected 1", valid_cnt - v0); end
    n_vec++;
    if (data_out !== 8'h3C) begin n_err++; $display("FAIL lock_data_out: got %02h, expected 3c", data_out); end
  endtask

  task automatic test_long_run;
    int v0, l0;
    v0 = valid_cnt; l0 = lost_cnt;
    check_spacing = 1'b1;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_bits(32'hFF, 8);
    send_bits(32'h00, 8);
    check_spacing = 1'b0;
    n_vec++;
    if ((valid_cnt - v0) !== 2) begin n_err++; $display("FAIL run_valid_count: got %0d, expected 2", valid_cnt - v0); end
    n_vec++;
    if ((lost_cnt - l0) !== 0) begin n_err++; $display("FAIL run_lock_lost: got %0d, expected 0", lost_cnt - l0); end
    n_vec++;
    if (locked !== 1'b1) begin n_err++; $display("FAIL run_locked: got %b, expected 1", locked); end
    n_vec++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL run_queue: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_lock_loss;
    int s_hold, l0, v0;
    s_hold = strobe_cnt; l0 = lost_cnt; v0 = valid_cnt;
    // 32 edgeless samples complete four all-ones bytes; the 33rd drops lock
    repeat (4) exp_q.push_back(8'hFF);
    for (int i = 0; i < 40; i++) send_bits(32'h1, 1);
    n_vec++;
    if ((lost_cnt - l0) !== 1) begin n_err++; $display("FAIL loss_count: got %0d, expected 1", lost_cnt - l0); end
    n_vec++;
    if ((strobe_at_lost - s_hold) !== 33) begin
      n_err++; $display("FAIL loss_sample_index: got %0d, expected 33", strobe_at_lost - s_hold);
    end
    n_vec++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL loss_locked: got %b, expected 0", locked); end
    n_vec++;
    if (dbg_state !== 2'd1) begin n_err++; $display("FAIL loss_state: got %0d, expected 1", dbg_state); end
    n_vec++;
    if ((valid_cnt - v0) !== 4) begin n_err++; $display("FAIL loss_valid_count: got %0d, expected 4", valid_cnt - v0); end
  endtask

  task automatic test_invalid_period;
    int s0, st0, v0;
    s0 = sync_cnt;
    send_bits(32'hA5C3, 16);
    n_vec++;
    if ((sync_cnt - s0) !== 1) begin n_err++; $display("FAIL relock_sync_count: got %0d, expected 1", sync_cnt - s0); end
    send_bits(32'h5, 3);
    signal = 1'b0;
    idle_cycles(30);
    bit_period = 16'd2;
    idle_cycles(1);
    n_vec++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL invalid_locked: got %b, expected 0", locked); end
    n_vec++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL invalid_state: got %0d, expected 0", dbg_state); end
    st0 = strobe_cnt; v0 = valid_cnt;
    for (int i = 0; i < 6; i++) begin
      signal = ~signal;
      idle_cycles(50);
    end
    n_vec++;
    if ((strobe_cnt - st0) !== 0) begin n_err++; $display("FAIL invalid_strobes: got %0d, expected 0", strobe_cnt - st0); end
    n_vec++;
    if ((valid_cnt - v0) !== 0) begin n_err++; $display("FAIL invalid_valid: got %0d, expected 0", valid_cnt - v0); end
    bit_period = 16'd100;
    idle_cycles(10);
    signal = 1'b1;
    idle_cycles(5);
    n_vec++;
    if (dbg_state !== 2'd1) begin n_err++; $display("FAIL restore_state: got %0d, expected 1", dbg_state); end
  endtask

  task automatic test_reset_mid_byte;
    int s0, v0;
    s0 = sync_cnt;
    send_bits(32'hA5C3, 16);
    send_bits(32'h16, 5);
    n_vec++;
    if ((sync_cnt - s0) !== 1 || locked !== 1'b1) begin
      n_err++; $display("FAIL midreset_prelock: got sync %0d locked %b, expected 1 1", sync_cnt - s0, locked);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bit_val, bit_strobe, locked, sync_found, lock_lost, data_valid, inverted} !== 7'b0) begin
      n_err++;
      $display("FAIL midreset_flags: got %07b, expected 0000000",
               {bit_val, bit_strobe, locked, sync_found, lock_lost, data_valid, inverted});
    end
    n_vec++;
    if (data_out !== 8'h00) begin n_err++; $display("FAIL midreset_data_out: got %02h, expected 00", data_out); end
    n_vec++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL midreset_state: got %0d, expected 0", dbg_state); end
    idle_cycles(3);
    rst_n = 1'b1;
    v0 = valid_cnt;
    send_bits(32'h3, 3);
    send_bits(32'h5A, 8);
    n_vec++;
    if ((valid_cnt - v0) !== 0) begin n_err++; $display("FAIL midreset_valid: got %0d, expected 0", valid_cnt - v0); end
    n_vec++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL midreset_locked: got %b, expected 0", locked); end
  endtask

  task automatic test_inverted_sync;
    int s0;
    s0 = sync_cnt;
    send_bits(32'h55, 8);
    send_bits(32'h5A3C, 16);
`ifdef SYNC_INVERT_EN
    exp_q.push_back(8'h3C);
    send_bits(32'hC3, 8);
    n_vec++;
    if ((sync_cnt - s0) !== 1) begin n_err++; $display("FAIL inv_sync_count: got %0d, expected 1", sync_cnt - s0); end
    n_vec++;
    if (inverted !== 1'b1) begin n_err++; $display("FAIL inv_flag: got %b, expected 1", inverted); end
    n_vec++;
    if (data_out !== 8'h3C) begin n_err++; $display("FAIL inv_data_out: got %02h, expected 3c", data_out); end
`else
    idle_cycles(5);
    n_vec++;
    if ((sync_cnt - s0) !== 0) begin n_err++; $display("FAIL inv_sync_count: got %0d, expected 0", sync_cnt - s0); end
    n_vec++;
    if (inverted !== 1'b0) begin n_err++; $display("FAIL inv_flag: got %b, expected 0", inverted); end
    n_vec++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL inv_locked: got %b, expected 0", locked); end
`endif
    n_vec++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL final_queue: got %0d left, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_lock_first_byte();
    test_long_run();
    test_lock_loss();
    test_invalid_period();
    test_reset_mid_byte();
    test_inverted_sync();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
